// File: rtl/fetch_pc_ctrl.sv
// Program counter and fetch control ahead of a 1-cycle registered instruction memory.
// Handles stall, branch redirect with wrong-path squash, HALT freeze and a delivered count.
module fetch_pc_ctrl #(
  parameter int unsigned      PC_W        = 12,
  parameter int unsigned      INSTR_W     = 16,
  parameter logic [PC_W-1:0]  RESET_PC    = '0,
  parameter logic [3:0]       HALT_OPCODE = 4'hF
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_stop,
  input  logic               i_branch_taken,
  input  logic [PC_W-1:0]    i_branch_target,
  input  logic [INSTR_W-1:0] i_instruction,
  output logic [PC_W-1:0]    o_pc,
  output logic [INSTR_W-1:0] o_if_instruction,
  output logic [PC_W-1:0]    o_if_pc,
  output logic               o_if_valid,
  output logic               o_halted,
  output logic [15:0]        o_fetch_cnt
);

  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] if_pc_q, if_pc_d;
  logic            if_valid_q, if_valid_d;
  logic            halted_q, halted_d;
  logic [15:0]     cnt_q, cnt_d;

  logic [3:0] opcode;
  logic       is_halt;
  logic       br;
  logic       hlt;
  logic       consume;

  always_comb begin
    opcode  = i_instruction[INSTR_W-1 -: 4];
    is_halt = (opcode == HALT_OPCODE);
    br      = i_branch_taken & if_valid_q & ~is_halt;
    hlt     = if_valid_q & is_halt & ~i_stop;
    // A HALT is consumed too, so it is counted along with ordinary instructions.
    consume = if_valid_q & ~i_stop & ~br;
  end

  always_comb begin
    pc_d       = pc_q;
    if_pc_d    = if_pc_q;
    if_valid_d = if_valid_q;
    halted_d   = halted_q;
    cnt_d      = cnt_q;
    if (!halted_q) begin
      if (br) begin
        // Redirect even under stall; the in-flight old-path word is squashed.
        pc_d       = i_branch_target;
        if_valid_d = 1'b0;
      end else if (i_stop) begin
        pc_d = pc_q;
      end else if (hlt) begin
        halted_d   = 1'b1;
        if_valid_d = 1'b0;
      end else begin
        pc_d       = pc_q + PC_W'(1);
        if_pc_d    = pc_q;
        if_valid_d = 1'b1;
      end
      if (consume && cnt_q != 16'hFFFF) begin
        cnt_d = cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      pc_q       <= RESET_PC;
      if_pc_q    <= '0;
      if_valid_q <= 1'b0;
      halted_q   <= 1'b0;
      cnt_q      <= '0;
    end else begin
      pc_q       <= pc_d;
      if_pc_q    <= if_pc_d;
      if_valid_q <= if_valid_d;
      halted_q   <= halted_d;
      cnt_q      <= cnt_d;
    end
  end

  assign o_pc             = pc_q;
  assign o_if_instruction = i_instruction;
  assign o_if_pc          = if_pc_q;
  assign o_if_valid       = if_valid_q;
  assign o_halted         = halted_q;
  assign o_fetch_cnt      = cnt_q;

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Directed bench for fetch_pc_ctrl with a behavioural 1-cycle registered instruction memory.
`timescale 1ns/100ps
module tb_fetch_pc_ctrl;

  logic        clk;
  logic        rst;
  logic        stop;
  logic        br_taken;
  logic [11:0] br_target;
  logic [15:0] rdata;
  logic [11:0] o_pc;
  logic [15:0] if_instr;
  logic [11:0] if_pc;
  logic        if_valid;
  logic        halted;
  logic [15:0] fetch_cnt;

  logic [15:0] mem [4096];

  int n_checks;
  int n_fail;

  fetch_pc_ctrl dut (
    .i_clk            (clk),
    .i_reset          (rst),
    .i_stop           (stop),
    .i_branch_taken   (br_taken),
    .i_branch_target  (br_target),
    .i_instruction    (rdata),
    .o_pc             (o_pc),
    .o_if_instruction (if_instr),
    .o_if_pc          (if_pc),
    .o_if_valid       (if_valid),
    .o_halted         (halted),
    .o_fetch_cnt      (fetch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered read, enable gated by the same stall signal as the DUT.
  always @(posedge clk) begin
    if (!stop) rdata <= mem[o_pc];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    stop = 1'b0;
    br_taken = 1'b0;
  endtask

  task automatic test_reset();
    // Reset asserted while stall and branch are also asserted.
    stop = 1'b1;
    br_taken = 1'b1;
    br_target = 12'h777;
    rst = 1'b1;
    step();
    step();
    n_checks++;
    if (o_pc !== 12'h000) begin n_fail++; $display("FAIL reset_pc: got %h want 000", o_pc); end
    n_checks++;
    if (if_valid !== 1'b0 || if_pc !== 12'h000) begin
      n_fail++; $display("FAIL reset_if: got valid=%b pc=%h want 0/000", if_valid, if_pc);
    end
    n_checks++;
    if (halted !== 1'b0 || fetch_cnt !== 16'h0000) begin
      n_fail++; $display("FAIL reset_state: got halted=%b cnt=%h want 0/0000", halted, fetch_cnt);
    end
    rst = 1'b0;
    stop = 1'b0;
    br_taken = 1'b0;
  endtask

  task automatic test_sequential();
    logic [15:0] exp_data [4];
    exp_data[0] = 16'h1438;
    exp_data[1] = 16'h282F;
    exp_data[2] = 16'h1121;
    exp_data[3] = 16'h1242;
    apply_reset();
    for (int k = 0; k < 4; k++) begin
      step();
      n_checks++;
      if (if_valid !== 1'b1 || if_pc !== 12'(k) || if_instr !== exp_data[k]) begin
        n_fail++;
        $display("FAIL seq_%0d: got v=%b pc=%h d=%h want 1/%h/%h", k, if_valid, if_pc, if_instr,
                 12'(k), exp_data[k]);
      end
    end
    step();
    n_checks++;
    if (fetch_cnt !== 16'd4) begin n_fail++; $display("FAIL seq_cnt: got %0d want 4", fetch_cnt); end
  endtask

  // Continues from test_sequential: pc_q=5, o_if_pc=4 valid.
  task automatic test_stall();
    stop = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      n_checks++;
      if (o_pc !== 12'h005 || if_pc !== 12'h004 || if_valid !== 1'b1 ||
          fetch_cnt !== 16'd4 || if_instr !== 16'h1004) begin
        n_fail++;
        $display("FAIL stall_%0d: got pc=%h ifpc=%h v=%b cnt=%0d d=%h want 005/004/1/4/1004",
                 k, o_pc, if_pc, if_valid, fetch_cnt, if_instr);
      end
    end
    stop = 1'b0;
    step();
    n_checks++;
    if (if_pc !== 12'h005 || if_valid !== 1'b1 || if_instr !== 16'h1005 || fetch_cnt !== 16'd5) begin
      n_fail++;
      $display("FAIL stall_resume: got ifpc=%h v=%b d=%h cnt=%0d want 005/1/1005/5",
               if_pc, if_valid, if_instr, fetch_cnt);
    end
    step();
    n_checks++;
    if (if_pc !== 12'h006 || fetch_cnt !== 16'd6) begin
      n_fail++; $display("FAIL stall_next: got ifpc=%h cnt=%0d want 006/6", if_pc, fetch_cnt);
    end
  endtask

  task automatic test_branch();
    apply_reset();
    step(); step(); step();
    br_taken = 1'b1;
    br_target = 12'h100;
    step();
    br_taken = 1'b0;
    n_checks++;
    if (if_valid !== 1'b0 || o_pc !== 12'h100 || fetch_cnt !== 16'd2) begin
      n_fail++;
      $display("FAIL br_squash: got v=%b pc=%h cnt=%0d want 0/100/2", if_valid, o_pc, fetch_cnt);
    end
    step();
    n_checks++;
    if (if_valid !== 1'b1 || if_pc !== 12'h100 || if_instr !== 16'h1100 || o_pc !== 12'h101) begin
      n_fail++;
      $display("FAIL br_target: got v=%b ifpc=%h d=%h pc=%h want 1/100/1100/101",
               if_valid, if_pc, if_instr, o_pc);
    end
    step();
    n_checks++;
    if (fetch_cnt !== 16'd3 || if_pc !== 12'h101) begin
      n_fail++; $display("FAIL br_cnt: got cnt=%0d ifpc=%h want 3/101", fetch_cnt, if_pc);
    end
  endtask

  task automatic test_branch_stall();
    apply_reset();
    step(); step(); step();
    br_taken = 1'b1;
    br_target = 12'h100;
    stop = 1'b1;
    step();
    br_taken = 1'b0;
    n_checks++;
    if (o_pc !== 12'h100 || if_valid !== 1'b0) begin
      n_fail++; $display("FAIL brst_redirect: got pc=%h v=%b want 100/0", o_pc, if_valid);
    end
    for (int k = 0; k < 2; k++) begin
      step();
      n_checks++;
      if (o_pc !== 12'h100 || if_valid !== 1'b0 || fetch_cnt !== 16'd2) begin
        n_fail++;
        $display("FAIL brst_hold_%0d: got pc=%h v=%b cnt=%0d want 100/0/2", k, o_pc, if_valid,
                 fetch_cnt);
      end
    end
    stop = 1'b0;
    step();
    n_checks++;
    if (if_valid !== 1'b1 || if_pc !== 12'h100 || if_instr !== 16'h1100 || fetch_cnt !== 16'd2) begin
      n_fail++;
      $display("FAIL brst_target: got v=%b ifpc=%h d=%h cnt=%0d want 1/100/1100/2",
               if_valid, if_pc, if_instr, fetch_cnt);
    end
  endtask

  task automatic test_halt();
    mem[3] = 16'hF000;
    apply_reset();
    step(); step(); step(); step();
    n_checks++;
    if (if_instr !== 16'hF000 || if_valid !== 1'b1 || halted !== 1'b0) begin
      n_fail++;
      $display("FAIL halt_present: got d=%h v=%b h=%b want F000/1/0", if_instr, if_valid, halted);
    end
    step();
    n_checks++;
    if (halted !== 1'b1 || if_valid !== 1'b0 || o_pc !== 12'h004 || fetch_cnt !== 16'd4) begin
      n_fail++;
      $display("FAIL halt_enter: got h=%b v=%b pc=%h cnt=%0d want 1/0/004/4",
               halted, if_valid, o_pc, fetch_cnt);
    end
    br_taken = 1'b1;
    br_target = 12'h200;
    for (int k = 0; k < 3; k++) begin
      stop = k[0];
      step();
      n_checks++;
      if (halted !== 1'b1 || if_valid !== 1'b0 || o_pc !== 12'h004 || if_pc !== 12'h003 ||
          fetch_cnt !== 16'd4) begin
        n_fail++;
        $display("FAIL halt_hold_%0d: got h=%b v=%b pc=%h ifpc=%h cnt=%0d want 1/0/004/003/4",
                 k, halted, if_valid, o_pc, if_pc, fetch_cnt);
      end
    end
    br_taken = 1'b0;
    stop = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_checks++;
    if (halted !== 1'b0 || o_pc !== 12'h000 || fetch_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL halt_reset: got h=%b pc=%h cnt=%0d want 0/000/0", halted, o_pc, fetch_cnt);
    end
    mem[3] = 16'h1242;
  endtask

  task automatic test_wrap_saturate();
    apply_reset();
    for (int n = 1; n <= 65538; n++) begin
      step();
      if (n == 4095) begin
        n_checks++;
        if (o_pc !== 12'hFFF) begin n_fail++; $display("FAIL wrap_pre: got %h want FFF", o_pc); end
      end
      if (n == 4096) begin
        n_checks++;
        if (o_pc !== 12'h000 || if_pc !== 12'hFFF || if_valid !== 1'b1) begin
          n_fail++;
          $display("FAIL wrap: got pc=%h ifpc=%h v=%b want 000/FFF/1", o_pc, if_pc, if_valid);
        end
      end
      if (n == 65535 || n == 65536 || n == 65538) begin
        n_checks++;
        if (fetch_cnt !== ((n == 65535) ? 16'hFFFE : 16'hFFFF)) begin
          n_fail++; $display("FAIL sat_%0d: got %h", n, fetch_cnt);
        end
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    rst = 1'b1;
    stop = 1'b0;
    br_taken = 1'b0;
    br_target = 12'h000;
    rdata = 16'h0000;
    for (int i = 0; i < 4096; i++) mem[i] = 16'h1000 | 16'(i);
    mem[0] = 16'h1438;
    mem[1] = 16'h282F;
    mem[2] = 16'h1121;
    mem[3] = 16'h1242;
    test_reset();
    test_sequential();
    test_stall();
    test_branch();
    test_branch_stall();
    test_halt();
    test_wrap_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
